// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit: datapath width,
// reset PC, fetch FSM encoding and the PC step.
package instruction_fetch_unit_pkg;

  localparam int                IFU_DATA_WIDTH = 32;
  localparam logic [31:0]       IFU_RESET_PC   = 32'h0040_0000;
  localparam int                PC_INCR        = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_prefetch_queue.sv
// Synchronous FIFO holding {pc, instruction} entries between fetch and decode.
// Flush empties it in one clock; a push into a full queue is accepted only alongside a pop.
module instruction_fetch_unit_prefetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[head];

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the asynchronous ROM and buffers
// {PC, instruction} pairs in a prefetch queue feeding decode.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH  = IFU_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = IFU_RESET_PC,
  parameter int                    QUEUE_DEPTH = 4,
  localparam int                   CW          = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Run,
  input  logic                  Redirect,
  input  logic [DATA_WIDTH-1:0] RedirectPC,
  output logic [DATA_WIDTH-1:0] MemAddress,
  input  logic [DATA_WIDTH-1:0] MemInstruction,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  output logic [DATA_WIDTH-1:0] InstrData,
  output logic [DATA_WIDTH-1:0] InstrPC,
  output logic [CW-1:0]         Occupancy,
  output fetch_state_t          state_dbg
);

  fetch_state_t                state_q;
  fetch_state_t                state_d;
  logic [DATA_WIDTH-1:0]       pc_q;
  logic [DATA_WIDTH-1:0]       redirect_target;
  logic [2*DATA_WIDTH-1:0]     head_entry;
  logic                        q_full;
  logic                        q_empty;
  logic                        push;
  logic                        pop;

  // Decode handshake: an entry transfers on any clock where InstrValid and
  // InstrReady are both high; while InstrValid is high and InstrReady low the
  // head (InstrData/InstrPC) is held unchanged.
  assign pop  = InstrValid && InstrReady;
  assign push = (state_q == FETCH) && !Redirect && (!q_full || pop);

  assign redirect_target = RedirectPC & ~DATA_WIDTH'(3);
  assign MemAddress      = pc_q;
  assign InstrValid      = !q_empty;
  assign InstrPC         = head_entry[2*DATA_WIDTH-1:DATA_WIDTH];
  assign InstrData       = head_entry[DATA_WIDTH-1:0];
  assign state_dbg       = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Run)  state_d = FETCH;
      FETCH:   if (!Run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Redirect outranks the sequential step; push is already suppressed then.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (Redirect) begin
      pc_q <= redirect_target;
    end else if (push) begin
      pc_q <= pc_q + DATA_WIDTH'(PC_INCR);
    end
  end

  instruction_fetch_unit_prefetch_queue #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (Redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_q, MemInstruction}),
    .rdata (head_entry),
    .full  (q_full),
    .empty (q_empty),
    .count (Occupancy)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit against a queue-based model of
// the fetch/decode contract, with directed scenarios before the random phase.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        run;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  occupancy;
  fetch_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: what decode should see, in order, plus the fetch PC.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_fetching;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .Run            (run),
    .Redirect       (redirect),
    .RedirectPC     (redirect_pc),
    .MemAddress     (mem_address),
    .MemInstruction (mem_instruction),
    .InstrValid     (instr_valid),
    .InstrReady     (instr_ready),
    .InstrData      (instr_data),
    .InstrPC        (instr_pc),
    .Occupancy      (occupancy),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + ((a - BASE) >> 2);
  endfunction

  assign mem_instruction = rom_word(mem_address);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model across one clock using the inputs currently driven.
  task automatic model_update();
    bit pop_m;
    bit push_m;
    if (reset) begin
      exp_q.delete();
      m_pc       = BASE;
      m_fetching = 1'b0;
    end else begin
      pop_m  = (exp_q.size() != 0) && instr_ready;
      push_m = m_fetching && !redirect && (exp_q.size() < 4 || pop_m);
      if (pop_m) void'(exp_q.pop_front());
      if (redirect) begin
        exp_q.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (push_m) begin
        exp_q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_fetching = run;
    end
  endtask

  task automatic compare();
    check("occupancy", 64'(occupancy), 64'(exp_q.size()));
    check("valid", 64'(instr_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("instr_pc", 64'(instr_pc), 64'(exp_q[0][63:32]));
      check("instr_data", 64'(instr_data), 64'(exp_q[0][31:0]));
    end
    check("mem_address", 64'(mem_address), 64'(m_pc));
    check("state", 64'(state_dbg), 64'(m_fetching));
  endtask

  // ---------------- driver ----------------
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit rst, input bit rn, input bit rdy,
                       input bit rd, input logic [31:0] rd_pc);
    reset       = rst;
    run         = rn;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rd_pc;
  endtask

  initial begin
    m_pc       = BASE;
    m_fetching = 1'b0;

    // Reset values
    drive(1, 0, 0, 0, 32'h0);
    step();
    step();
    check("reset_data", 64'(instr_data), 64'h0);
    check("reset_pc", 64'(instr_pc), 64'h0);
    check("reset_addr", 64'(mem_address), 64'(BASE));

    // Streaming at one per clock
    drive(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 10; i++) step();

    // Back-pressure fills the queue, then drains without gaps
    drive(1, 0, 0, 0, 32'h0);
    step();
    drive(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++) step();
    check("sat_occupancy", 64'(occupancy), 64'd4);
    check("sat_addr", 64'(mem_address), 64'h0040_0010);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Redirect on a full queue, unaligned target
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    drive(0, 1, 0, 1, 32'h0040_0023);
    step();
    check("redir_flush", 64'(occupancy), 64'd0);
    redirect = 1'b0;
    step();
    step();
    check("redir_valid", 64'(instr_valid), 64'd1);
    check("redir_target", 64'(instr_pc), 64'h0040_0020);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Redirect coinciding with an accepted pop
    drive(0, 1, 1, 1, 32'h0040_0100);
    step();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Drop Run with entries buffered, then drain
    drive(1, 0, 0, 0, 32'h0);
    step();
    drive(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 10 && exp_q.size() < 3; i++) step();
    run = 1'b0;
    step();
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("drain_valid", 64'(instr_valid), 64'd0);
    check("drain_state", 64'(state_dbg), 64'(IDLE));

    // Reset mid-stream, full, with Redirect also asserted
    drive(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) step();
    drive(1, 1, 1, 1, 32'h1234_5678);
    step();
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_addr", 64'(mem_address), 64'(BASE));

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
